// File: rtl/pipe_ctrl_n_pkg.sv
// Shared types and helpers for the pipe_ctrl_n pipeline control unit.
// Exports: state_e (FSM encoding) and width_of() for counter sizing.
package pipe_ctrl_n_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MCWAIT = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_n_if.sv
// Request/response bundle between the pipeline and pipe_ctrl_n.
// master: pipeline side (drives requests); slave: control unit.
interface pipe_ctrl_n_if #(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned CNT_W  = 32
);

    logic [NSTAGE-1:0] stallreq;
    logic              mc_start;
    logic              mc_done;
    logic              flush_req;
    logic [31:0]       flush_pc;

    logic [NSTAGE:0]   stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              new_pc_valid;
    logic              mc_busy;
    logic              mc_abort;
    logic              mc_err;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stallreq, mc_start, mc_done, flush_req, flush_pc,
        input  stall, flush, new_pc, new_pc_valid,
        input  mc_busy, mc_abort, mc_err, stall_cnt
    );

    modport slave (
        input  stallreq, mc_start, mc_done, flush_req, flush_pc,
        output stall, flush, new_pc, new_pc_valid,
        output mc_busy, mc_abort, mc_err, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_n_sat_counter.sv
// Saturating up-counter: +1 per cycle with inc_i high, sticks at all-ones.
// Ports: clk, rst_n (async, active-low), inc_i, cnt_o[W-1:0].
module pipe_ctrl_n_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline control: stall merging, multi-cycle op sequencing, flush/redirect.
// Ports: clk, rst (async, active-low), bus (pipe_ctrl_n_if.slave).
module pipe_ctrl_n
    import pipe_ctrl_n_pkg::*;
#(
    parameter int unsigned NSTAGE     = 5,
    parameter int unsigned MC_STAGE   = 2,
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned FLUSH_CYC  = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_n_if.slave  bus
);

    localparam int unsigned SBW = NSTAGE + 1;
    localparam int unsigned TW  = width_of(MC_TIMEOUT);
    localparam int unsigned FW  = width_of(FLUSH_CYC);

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [31:0]   new_pc_q, new_pc_d;
    logic          npv_q, npv_d;
    logic          abort_q, abort_d;
    logic          err_q, err_d;

    logic          mc_hold;
    logic [SBW-1:0] stall_raw;
    logic [SBW-1:0] stall_w;
    logic          flushing;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        fcnt_d   = fcnt_q;
        new_pc_d = new_pc_q;
        npv_d    = 1'b0;
        abort_d  = 1'b0;
        err_d    = 1'b0;

        // A flush request wins from any state and restarts the hold count.
        if (bus.flush_req) begin
            state_d  = ST_FLUSH;
            fcnt_d   = FW'(FLUSH_CYC - 1);
            new_pc_d = bus.flush_pc;
            npv_d    = 1'b1;
            abort_d  = (state_q == ST_MCWAIT);
        end else begin
            case (state_q)
                ST_RUN: begin
                    // start+done together is a zero-wait op: stay in RUN
                    if (bus.mc_start && !bus.mc_done) begin
                        state_d = ST_MCWAIT;
                        tmo_d   = '0;
                    end
                end
                ST_MCWAIT: begin
                    if (bus.mc_done) begin
                        state_d = ST_RUN;
                    end else if (tmo_q == TW'(MC_TIMEOUT - 1)) begin
                        state_d = ST_RUN;
                        abort_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q - FW'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            tmo_q    <= '0;
            fcnt_q   <= '0;
            new_pc_q <= '0;
            npv_q    <= 1'b0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            fcnt_q   <= fcnt_d;
            new_pc_q <= new_pc_d;
            npv_q    <= npv_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
        end
    end

    // ---------------- stall vector ----------------
    // The waiting multi-cycle op stalls its own stage until done arrives.
    assign mc_hold  = (state_q == ST_MCWAIT) && !bus.mc_done;
    assign flushing = (state_q == ST_FLUSH);

    // Highest requesting stage s freezes PC..stage s; stage s+1 gets a bubble.
    always_comb begin
        stall_raw = '0;
        for (int i = 0; i < int'(NSTAGE); i++) begin
            if (bus.stallreq[i] || (mc_hold && (i == int'(MC_STAGE)))) begin
                for (int j = 0; j < int'(SBW); j++) begin
                    stall_raw[j] = (j <= i + 1);
                end
            end
        end
    end

    // Outputs are all zero while reset is held, including the comb stall bus.
    assign stall_w = (rst && !flushing) ? stall_raw : '0;

    pipe_ctrl_n_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (stall_w[0]),
        .cnt_o (bus.stall_cnt)
    );

    assign bus.stall        = stall_w;
    assign bus.flush        = flushing;
    assign bus.new_pc       = new_pc_q;
    assign bus.new_pc_valid = npv_q;
    assign bus.mc_busy      = (state_q == ST_MCWAIT);
    assign bus.mc_abort     = abort_q;
    assign bus.mc_err       = err_q;

endmodule
